// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared stall-controller state encoding and pipeline register indices
package rv32i_types;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } pipe_ctrl_state_t;

  localparam int STG_PC  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/resp_tracker.sv
// rtl/resp_tracker.sv - per-cache wait term plus a flag remembering a response that landed during a freeze
module resp_tracker (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic resp,
  input  logic freeze,
  output logic pending,
  output logic done
);

  assign pending = req & ~resp & ~done;

  // The request stays asserted while frozen, so the flag stands in for the consumed response.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else if (!freeze) begin
      done <= 1'b0;
    end else if (req && resp) begin
      done <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush/load control for a 5-register in-order pipeline
// Optional perf counters: PIPE_CTRL_PERF_EN
module pipeline_stall_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_a,
  input  logic                  resp_a,
  input  logic                  read_b,
  input  logic                  write_b,
  input  logic                  resp_b,
  input  logic                  redirect,
  input  logic                  load_use,
  output logic [NUM_STAGES-1:0] load,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  stall,
  output logic                  ir_capture,
  output logic                  ir_sel
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  if (NUM_STAGES <= STG_EX || CNT_W < 1) begin : g_bad_params
    $error("pipeline_stall_ctrl: NUM_STAGES must exceed STG_EX and CNT_W must be positive");
  end

  pipe_ctrl_state_t state;
  logic i_wait, d_wait, i_done, d_done;

  resp_tracker u_i_track (
    .clk(clk), .reset(reset), .req(read_a), .resp(resp_a),
    .freeze(stall), .pending(i_wait), .done(i_done)
  );

  resp_tracker u_d_track (
    .clk(clk), .reset(reset), .req(read_b | write_b), .resp(resp_b),
    .freeze(stall), .pending(d_wait), .done(d_done)
  );

  assign stall      = ~reset & (i_wait | d_wait);
  assign ir_capture = stall & read_a & resp_a & ~i_done;
  assign ir_sel     = ~reset & i_done;

  always_comb begin
    load  = '0;
    flush = '0;
    if (reset) begin
      flush = '1;
    end else if (!stall) begin
      load = '1;
      // Redirect wins: the load-use dependent sits on the wrong path anyway.
      if (redirect) begin
        for (int k = 1; k < NUM_STAGES; k++) begin
          if (k <= FLUSH_DEPTH) flush[k] = 1'b1;
        end
      end else if (load_use) begin
        load[STG_PC]  = 1'b0;
        load[STG_ID]  = 1'b0;
        flush[STG_EX] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= stall ? WAIT : RUN;
  end

  flags_only_in_wait: assert property (@(posedge clk) disable iff (reset)
    (i_done | d_done) |-> (state == WAIT));

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (!stall && redirect && flush_events != '1) flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule
